vga_fb_reader: RTL

Framebuffer read stage directly upstream of the VGA raster core. Mirrors the 800x600 raster counters in lockstep with the core and drives a synchronous-read framebuffer RAM one cycle ahead of the raster. Presents each 8-bit RRRGGGBB pixel on `vg__color` in exactly the cycle the core consumes it, upscaling a 200x150 source image 4x in each axis. Checks its own raster prediction against the core's `vg__stall` and flags any mismatch.

---
 rtl/vga_fb_reader_if.sv | 11 +
 rtl/vga_fb_reader.sv | 60 ++++++
 2 files changed

// File: rtl/vga_fb_reader_if.sv
// vga_fb_reader_if: raster-side and framebuffer-side signals of the framebuffer read stage.
interface vga_fb_reader_if #(parameter int ADDR_BITS = 15);
   logic vg__stall;
   logic [7:0] vg__color;
   logic [ADDR_BITS-1:0] fb__addr;
   logic [7:0] fb__data;
   logic fb__vblank;
   logic rd__desync;
   modport master(input vg__stall, fb__data, output vg__color, fb__addr, fb__vblank, rd__desync);
   modport slave(output vg__stall, fb__data, input vg__color, fb__addr, fb__vblank, rd__desync);
endinterface

// File: rtl/vga_fb_reader.sv
// vga_fb_reader: mirrors the raster counters and fetches 4x-upscaled framebuffer pixels one cycle
// ahead of the core, flagging any disagreement with the core's blanking indicator.
module vga_fb_reader #(
   parameter int HOR_ADDR = 800,
   parameter int HOR_TOTAL = 1040,
   parameter int VER_ADDR = 600,
   parameter int VER_TOTAL = 666,
   parameter int SRC_W = 200,
   parameter int ADDR_BITS = 15
) (
   input logic clk,
   input logic rst,
   vga_fb_reader_if.master bus
);
   localparam logic [10:0] H_ACT = 11'(HOR_ADDR);
   localparam logic [10:0] H_END = 11'(HOR_TOTAL - 1);
   localparam logic [10:0] H_LOAD = 11'(HOR_ADDR - 2);
   localparam logic [9:0] V_ACT = 10'(VER_ADDR);
   localparam logic [9:0] V_END = 10'(VER_TOTAL - 1);
   localparam logic [9:0] V_LAST = 10'(VER_ADDR - 1);
   localparam logic [ADDR_BITS-1:0] ROW_STEP = ADDR_BITS'(SRC_W);
   logic [10:0] h;
   logic [9:0] v;
   logic [1:0] cp, rp;
   logic [7:0] col;
   logic [ADDR_BITS-1:0] rb, addr, next_rb;
   logic pstall, desync;
   assign pstall = (h >= H_ACT) || (v >= V_ACT);
   // rb/rp describe the line the address register points into; they move to the next line two
   // cycles before the end of the active part, when the fetch target leaves the line
   assign next_rb = (v >= V_LAST) ? '0 : rb + ((rp == 2'd3) ? ROW_STEP : '0);
   always_ff @(posedge clk)
      if (rst) begin
         h <= '0;
         v <= '0;
         cp <= '0;
         col <= '0;
         rp <= '0;
         rb <= '0;
         addr <= '0;
         desync <= 1'b0;
      end else begin
         h <= (h == H_END) ? '0 : h + 11'd1;
         if (h == H_END) v <= (v == V_END) ? '0 : v + 10'd1;
         cp <= (h == H_END) ? '0 : cp + 2'd1;
         col <= (h == H_END) ? '0 : (h < H_ACT && cp == 2'd3) ? col + 8'd1 : col;
         // target is h+2; its column is col+1 exactly when the phase is 2 or 3
         if (h < H_LOAD && v < V_ACT) addr <= rb + ADDR_BITS'(col) + ADDR_BITS'(cp[1]);
         else if (h == H_LOAD) begin
            addr <= next_rb;
            rb <= next_rb;
            rp <= (v >= V_LAST) ? '0 : rp + 2'd1;
         end
         desync <= desync | (bus.vg__stall != pstall);
      end
   assign bus.vg__color = pstall ? '0 : bus.fb__data;
   assign bus.fb__addr = addr;
   assign bus.fb__vblank = v >= V_ACT;
   assign bus.rd__desync = desync;
endmodule
